// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared types and default timing constants for the push-button front end
package pb_pkg;

    // Debounce FSM states; UP is the released/idle state.
    typedef enum logic [1:0] {
        UP     = 2'd0,
        DEB_DN = 2'd1,
        DOWN   = 2'd2,
        DEB_UP = 2'd3
    } pb_state_t;

    // 10 ms of stable samples at 50 MHz.
    localparam int unsigned DEB_CYCLES_DEF  = 500000;
    // 2 s of hold at 50 MHz before a long press is reported.
    localparam int unsigned LONG_CYCLES_DEF = 100000000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Shift the raw input through two flops; reset loads the inactive level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - synchronized, debounced push button with press/release/long-press pulses
module pb_debounce
    import pb_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic PB,
    input  logic en,
    output logic pb_level,
    output logic pressed,
    output logic released,
    output logic long_press
);

    localparam int unsigned DW = $clog2(DEB_CYCLES);
    localparam int unsigned HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    // Synchronized button; 0 means pressed. Resets to released.
    logic s2;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (PB),
        .q_o (s2)
    );

    pb_state_t     state_q;
    logic [DW-1:0] deb_cnt_q;
    logic [HW-1:0] hold_cnt_q;
    logic [HW-1:0] hold_cnt_d;
    logic          hold_run_d;
    logic          pb_level_q;
    logic          pressed_q;
    logic          released_q;
    logic          long_press_q;

    // Hold time advances only while the button is considered down, saturating at the last count.
    always_comb begin
        hold_run_d = ((state_q == DOWN) || (state_q == DEB_UP)) && (hold_cnt_q < HOLD_LAST);
        hold_cnt_d = hold_cnt_q + HW'(1);
    end

    // Debounce FSM with registered level and single-cycle event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= UP;
            deb_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            pb_level_q   <= 1'b0;
            pressed_q    <= 1'b0;
            released_q   <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            pressed_q    <= 1'b0;
            released_q   <= 1'b0;
            long_press_q <= 1'b0;
            if (!en) begin
                // Disabled: drop to idle so a held button must requalify on re-enable.
                state_q    <= UP;
                pb_level_q <= 1'b0;
            end else begin
                if (hold_run_d) begin
                    hold_cnt_q   <= hold_cnt_d;
                    long_press_q <= (hold_cnt_d == HOLD_LAST);
                end
                case (state_q)
                    UP: begin
                        if (!s2) begin
                            state_q   <= DEB_DN;
                            deb_cnt_q <= '0;
                        end
                    end
                    DEB_DN: begin
                        if (s2) begin
                            state_q <= UP;
                        end else if (deb_cnt_q == DEB_LAST) begin
                            state_q    <= DOWN;
                            hold_cnt_q <= '0;
                            pressed_q  <= 1'b1;
                            pb_level_q <= 1'b1;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + DW'(1);
                        end
                    end
                    DOWN: begin
                        if (s2) begin
                            state_q   <= DEB_UP;
                            deb_cnt_q <= '0;
                        end
                    end
                    DEB_UP: begin
                        // A bounce back to pressed keeps the accumulated hold time.
                        if (!s2) begin
                            state_q <= DOWN;
                        end else if (deb_cnt_q == DEB_LAST) begin
                            state_q    <= UP;
                            released_q <= 1'b1;
                            pb_level_q <= 1'b0;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + DW'(1);
                        end
                    end
                    default: state_q <= UP;
                endcase
            end
        end
    end

    assign pb_level   = pb_level_q;
    assign pressed    = pressed_q;
    assign released   = released_q;
    assign long_press = long_press_q;

endmodule

// File: tb/tb_pb_debounce.sv
// tb/tb_pb_debounce.sv - self-checking bench for pb_debounce
module tb_pb_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic PB  = 1'b1;
    logic en  = 1'b1;
    logic pb_level;
    logic pressed;
    logic released;
    logic long_press;

    pb_debounce #(
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PB         (PB),
        .en         (en),
        .pb_level   (pb_level),
        .pressed    (pressed),
        .released   (released),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: synchronizer as a two-deep delay line, debounce as a run length of
    // samples disagreeing with the accepted level, long press as age since acceptance.
    logic m_s1, m_s2, m_level, mp, mr, ml;
    int   m_run, m_age;

    typedef struct {
        logic pb;
        logic en;
        logic lvl;
        logic p;
        logic r;
        logic l;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0;
        m_run = 0; m_age = LONG - 1;
        mp = 1'b0; mr = 1'b0; ml = 1'b0;
    endtask

    task automatic model_edge(input logic pb_v, input logic en_v);
        logic was_level;
        mp = 1'b0; mr = 1'b0; ml = 1'b0;
        was_level = m_level;
        if (!en_v) begin
            m_level = 1'b0;
            m_run   = 0;
        end else begin
            if ((!m_s2) != m_level) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_level = ~m_level;
                    m_run   = 0;
                    if (m_level) begin
                        mp    = 1'b1;
                        m_age = 0;
                    end else begin
                        mr = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
            if (was_level && m_age < LONG - 1) begin
                m_age++;
                if (m_age == LONG - 1) ml = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = pb_v;
    endtask

    // Drive inputs for the next edge, advance one clock, sample 1 ns after the edge.
    task automatic tick(input logic pb_v, input logic en_v);
        PB = pb_v;
        en = en_v;
        @(posedge clk);
        model_edge(pb_v, en_v);
        #1;
    endtask

    task automatic chk_model();
        chk("rand_level", pb_level, m_level);
        chk("rand_pressed", pressed, mp);
        chk("rand_released", released, mr);
        chk("rand_long", long_press, ml);
    endtask

    task automatic do_reset();
        PB  = 1'b1;
        en  = 1'b1;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_level", pb_level, 1'b0);
        chk("reset_pressed", pressed, 1'b0);
        chk("reset_released", released, 1'b0);
        chk("reset_long", long_press, 1'b0);
        rst = 1'b0;
    endtask

    task automatic add_row(input logic pb_v, input logic en_v, input logic lvl,
                           input logic p, input logic r, input logic l);
        vec_t v;
        v.pb = pb_v; v.en = en_v; v.lvl = lvl; v.p = p; v.r = r; v.l = l;
        tbl.push_back(v);
    endtask

    initial begin
        int run_left;
        logic pb_r, en_r;

        // Idle after reset, clean press, release overlapping the long-press point, short bounces.
        for (int i = 0; i < 20; i++) add_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) add_row(1'b0, 1'b1, (i >= 6), (i == 6), 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) add_row(1'b1, 1'b1, (j < 6), 1'b0, (j == 6), (j == 3));
        for (int i = 0; i < 3; i++)  add_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  add_row(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++)  add_row(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)  add_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        do_reset();
        foreach (tbl[k]) begin
            tick(tbl[k].pb, tbl[k].en);
            chk("tbl_level", pb_level, tbl[k].lvl);
            chk("tbl_pressed", pressed, tbl[k].p);
            chk("tbl_released", released, tbl[k].r);
            chk("tbl_long", long_press, tbl[k].l);
        end

        // Long hold then clean release.
        do_reset();
        for (int i = 0; i < 25; i++) begin
            tick(1'b0, 1'b1);
            chk("hold_pressed", pressed, (i == 6));
            chk("hold_long", long_press, (i == 15));
            chk("hold_level", pb_level, (i >= 6));
            chk("hold_released", released, 1'b0);
        end
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1'b1);
            chk("rel_released", released, (i == 6));
            chk("rel_level", pb_level, (i < 6));
            chk("rel_long", long_press, 1'b0);
        end

        // Release bounce during hold must not restart the hold count.
        do_reset();
        for (int i = 0; i < 25; i++) begin
            tick((i == 8 || i == 9), 1'b1);
            chk("bnc_pressed", pressed, (i == 6));
            chk("bnc_released", released, 1'b0);
            chk("bnc_long", long_press, (i == 15));
            chk("bnc_level", pb_level, (i >= 6));
        end

        // Disable while held, then re-enable: full requalification needed.
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0);
            chk("dis_level", pb_level, 1'b0);
            chk("dis_pressed", pressed, 1'b0);
        end
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 1'b1);
            chk("reen_pressed", pressed, (i == 4));
            chk("reen_level", pb_level, (i >= 4));
        end

        // Half-cycle asynchronous reset while held.
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
        chk("pre_arst_level", pb_level, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_level", pb_level, 1'b0);
        chk("arst_pressed", pressed, 1'b0);
        chk("arst_released", released, 1'b0);
        chk("arst_long", long_press, 1'b0);
        #4;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 1'b1);
            chk("post_arst_pressed", pressed, (i == 6));
            chk("post_arst_level", pb_level, (i >= 6));
        end

        // Random bouncing against the reference model.
        do_reset();
        run_left = 0;
        pb_r = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if (run_left == 0) begin
                pb_r = ~pb_r;
                run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 20) : $urandom_range(1, 6);
            end
            run_left--;
            en_r = ($urandom_range(0, 39) != 0);
            tick(pb_r, en_r);
            chk_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pb_debounce.md
# pb_debounce

Debounced push-button front end. Consumes the raw asynchronous button input and the chip's synchronized reset, and sits directly downstream of the reset synchronizer. Resolves metastability with a two-flop synchronizer, then rejects bounce with a debounce state machine. Produces a stable level plus single-cycle press, release and long-press pulses for the command/tour-start logic.

## Interface
- `DEB_CYCLES`, default 500000: stable-sample count required to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- `LONG_CYCLES`, default 100000000: held duration, counted from `pressed`, that triggers `long_press`; must be ≥ 2.
- `clk`  in  1: single clock; all flops use posedge `clk`.
- `rst`  in  1: reset, asynchronous and active-high; a high level clears all state immediately.
- `PB`  in  1: raw button, asynchronous, active-low (0 = pressed).
- `en`  in  1: enable; 0 forces state UP and suppresses all outputs.
- `pb_level`  out  1: debounced level, 1 = pressed; reset 0.
- `pressed`  out  1: one-cycle pulse on accepted press; reset 0.
- `released`  out  1: one-cycle pulse on accepted release; reset 0.
- `long_press`  out  1: one-cycle pulse, at most once per press; reset 0.

## Operation
- Synchronizer: `PB` → `s1` → `s2`; both flops reset to 1 (released). The FSM sees only `s2`.
- `deb_cnt` is `$clog2(DEB_CYCLES)` bits; `hold_cnt` is `$clog2(LONG_CYCLES)` bits. Both reset to 0.
- FSM states: UP, DEB_DN, DOWN, DEB_UP; reset state UP.
- UP:
  - `pb_level`=0.
  - If `s2`==0: go to DEB_DN and set `deb_cnt`←0.
- DEB_DN:
  - `pb_level`=0.
  - If `s2`==1: return to UP with no pulse (glitch rejected).
  - Else if `deb_cnt`==DEB_CYCLES-1: go to DOWN, set `hold_cnt`←0, assert `pressed`.
  - Else `deb_cnt`++.
- DOWN:
  - `pb_level`=1.
  - If `s2`==1: go to DEB_UP and set `deb_cnt`←0.
- DEB_UP:
  - `pb_level`=1.
  - If `s2`==0: return to DOWN; `hold_cnt` is NOT cleared.
  - Else if `deb_cnt`==DEB_CYCLES-1: go to UP and assert `released`.
  - Else `deb_cnt`++.
- Hold counter:
  - Increments at each edge while in DOWN or DEB_UP, only while `hold_cnt` < LONG_CYCLES-1; it saturates there.
  - `long_press` is asserted on the edge where the new value equals LONG_CYCLES-1.
  - `long_press` and `released` may assert in the same cycle; both are asserted.
- `en`=0:
  - The next edge forces state UP, `pb_level`=0, all pulses 0.
  - The synchronizer keeps running.
  - On re-enable with the button held, a full DEB_DN qualification is required.
- Reset mid-operation: all outputs drop to 0 asynchronously; any in-flight pulse is lost. After reset the FSM restarts from UP.

## Timing
- All outputs are registered; pulses are exactly one cycle wide.
- Press latency: `PB` low and stable, first sampled at edge k:
  - `s2`=0 after edge k+1.
  - DEB_DN entered at edge k+2.
  - `pressed` and `pb_level` high after edge k+2+DEB_CYCLES.
- Release latency: symmetric; `released` high and `pb_level` low after edge k+2+DEB_CYCLES.
- `long_press` comes LONG_CYCLES-1 cycles after `pressed`, provided no completed release intervenes.
- Any bounce shorter than DEB_CYCLES consecutive `s2` samples produces no output change.

## Structure
- Package `pb_pkg`:
  - `typedef enum logic [1:0] {UP, DEB_DN, DOWN, DEB_UP} pb_state_t`.
  - Default parameter constants.
- Sub-module `sync_2ff`: two-flop synchronizer with parameterized reset value. Reused for other asynchronous inputs.
- Counter widths are local parameters derived with `$clog2`.

## Test plan
Scenarios 1–5 use DEB_CYCLES=4 and LONG_CYCLES=10.
1. Reset high, `PB`=1, then reset low → all outputs 0, state UP; idle for 20 cycles keeps outputs 0.
2. `PB` driven to 0 at edge 0 and held → `pressed` high exactly in the cycle after edge 6 and only there; `pb_level`=1 from then on.
3. `PB` low for 3 cycles, high, low for 2 cycles, then high → no `pressed`, `pb_level` stays 0.
4. Press accepted, hold → `long_press` 9 cycles after `pressed`, single pulse; release → `released` 6 cycles after `PB` rises, `pb_level`=0.
5. Press accepted, then 2-cycle release bounce, then held → no `released`; `long_press` still at 9 cycles after `pressed` (`hold_cnt` not cleared).
6. Button held and `pb_level`=1, then `rst` pulsed for half a cycle → outputs 0 immediately; after reset, `pressed` re-asserts 6 cycles after the first `PB` sampling edge.
